// File: rtl/lpt_peripheral_receiver.sv
// Peripheral (printer) end of an SPP/Centronics link: synchronises the host pins,
// runs the STROBE/BUSY/ACK handshake and buffers received bytes in a small FIFO.
module lpt_peripheral_receiver #(
  parameter int FIFO_DEPTH     = 16,
  parameter int ACK_CYCLES     = 166,
  parameter int STB_MIN_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data,
  input  logic                          STROBE,
  input  logic                          AFD,
  input  logic                          INIT,
  input  logic                          SIN,
  output logic                          ACK,
  output logic                          BUSY,
  output logic                          PE,
  output logic                          SELT,
  output logic                          ERR,
  input  logic                          online,
  input  logic                          paper_out,
  input  logic                          fault,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          autofeed,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STB_MIN_CYCLES + 1);
  localparam int AW = $clog2(ACK_CYCLES + 1);
  localparam logic [SW-1:0] STB_LAST   = SW'(STB_MIN_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_CYCLES - 1);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_STB_LOW, S_WRITE, S_ACK_PULSE, S_INIT
  } state_t;

  state_t state_reg, state_next;

  logic [11:0]   sync1_reg, sync2_reg;
  logic [7:0]    data_sync;
  logic          strobe_sync, afd_sync, init_sync, sin_sync;

  logic [SW-1:0] stb_cnt_reg, stb_cnt_next;
  logic [AW-1:0] ack_cnt_reg, ack_cnt_next;
  logic [7:0]    cap_reg;
  logic          capture;
  logic          ack_reg, ack_next, busy_reg, busy_next;
  logic          pe_reg, selt_reg, err_reg;
  logic          overflow_reg, overflow_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [PW:0]   count_reg, count_next;
  logic          full, empty, push, pop, flush;
  logic [7:0]    mem [FIFO_DEPTH];

  // Data travels through the same two flops as STROBE so the captured byte is coherent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 12'h00F;
      sync2_reg <= 12'h00F;
    end else begin
      sync1_reg <= {data, STROBE, AFD, INIT, SIN};
      sync2_reg <= sync1_reg;
    end
  end

  assign data_sync   = sync2_reg[11:4];
  assign strobe_sync = sync2_reg[3];
  assign afd_sync    = sync2_reg[2];
  assign init_sync   = sync2_reg[1];
  assign sin_sync    = sync2_reg[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (!strobe_sync && stb_cnt_reg == STB_LAST) state_next = S_STB_LOW;
      S_STB_LOW:   if (strobe_sync) state_next = S_WRITE;
      S_WRITE:     state_next = S_ACK_PULSE;
      S_ACK_PULSE: if (ack_cnt_reg == ACK_LAST) state_next = S_IDLE;
      S_INIT:      if (init_sync) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (!init_sync) state_next = S_INIT;
  end

  always_comb begin
    full          = (count_reg == FULL_COUNT);
    empty         = (count_reg == '0);
    flush         = !init_sync;
    capture       = (state_reg == S_IDLE) && (state_next == S_STB_LOW);
    push          = (state_reg == S_WRITE) && !full && !flush;
    pop           = !empty && rx_ready && !flush;
    ack_next      = (state_next != S_ACK_PULSE);
    busy_next     = !((state_reg == S_IDLE) && !full && online && !fault && init_sync);
    stb_cnt_next  = '0;
    if ((state_reg == S_IDLE) && !strobe_sync && (state_next == S_IDLE))
      stb_cnt_next = stb_cnt_reg + SW'(1);
    ack_cnt_next  = (state_reg == S_ACK_PULSE) ? ack_cnt_reg + AW'(1) : '0;
    overflow_next = overflow_reg;
    if (flush)
      overflow_next = 1'b0;
    else if ((state_reg == S_WRITE) && full)
      overflow_next = 1'b1;
    wr_ptr_next = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    count_next  = count_reg;
    if (push && !pop)
      count_next = count_reg + (PW + 1)'(1);
    else if (pop && !push)
      count_next = count_reg - (PW + 1)'(1);
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stb_cnt_reg  <= '0;
      ack_cnt_reg  <= '0;
      cap_reg      <= '0;
      ack_reg      <= 1'b1;
      busy_reg     <= 1'b1;
      pe_reg       <= 1'b0;
      selt_reg     <= 1'b0;
      err_reg      <= 1'b1;
      overflow_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      stb_cnt_reg  <= stb_cnt_next;
      ack_cnt_reg  <= ack_cnt_next;
      if (capture) cap_reg <= data_sync;
      ack_reg      <= ack_next;
      busy_reg     <= busy_next;
      pe_reg       <= paper_out;
      selt_reg     <= online & !sin_sync;
      err_reg      <= !fault;
      overflow_reg <= overflow_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Head is read combinationally so rx_data is valid in the same cycle as rx_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= cap_reg;
  end

  assign rx_data    = mem[rd_ptr_reg];
  assign rx_valid   = !empty;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;
  assign autofeed   = !afd_sync;
  assign ACK        = ack_reg;
  assign BUSY       = busy_reg;
  assign PE         = pe_reg;
  assign SELT       = selt_reg;
  assign ERR        = err_reg;

endmodule

// File: tb/tb_lpt_peripheral_receiver.sv
// Self-checking bench for lpt_peripheral_receiver: directed handshake/INIT/status
// sequences plus randomized byte traffic scored against a queue-based model.
module tb_lpt_peripheral_receiver;
  localparam int DEPTH = 16;
  localparam int ACKC  = 12;
  localparam int STBM  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       STROBE, AFD, INIT, SIN;
  logic       ACK, BUSY, PE, SELT, ERR;
  logic       online, paper_out, fault;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       autofeed, overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  lpt_peripheral_receiver #(
    .FIFO_DEPTH(DEPTH), .ACK_CYCLES(ACKC), .STB_MIN_CYCLES(STBM)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .STROBE(STROBE), .AFD(AFD),
    .INIT(INIT), .SIN(SIN), .ACK(ACK), .BUSY(BUSY), .PE(PE), .SELT(SELT),
    .ERR(ERR), .online(online), .paper_out(paper_out), .fault(fault),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .autofeed(autofeed), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue, sticky overflow, expected/observed handshake counts.
  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;
  logic [7:0] pend_byte = 8'h00;
  int         exp_acks = 0;
  int         ack_seen = 0;
  int         pops = 0;
  bit         ack_len_chk = 1'b1;
  bit         rand_rdy = 1'b0;
  int         rdy_num = 16;

  typedef struct {
    logic online, fault, paper_out, sin, afd;
    logic busy, err, pe, selt, autofeed;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rx_ready = ($urandom_range(0, 63) < rdy_num);
  endtask

  task automatic wait_ack(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (ACK === lvl) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int low);
    bit ok;
    pend_byte = b;
    data      = b;
    STROBE    = 1'b0;
    repeat (low) tick();
    STROBE = 1'b1;
    exp_acks++;
    wait_ack(1'b0, ok);
    check("ack_fall_seen", 32'(ok), 32'd1);
    wait_ack(1'b1, ok);
    check("ack_rise_seen", 32'(ok), 32'd1);
    repeat (2) tick();
  endtask

  task automatic glitch(input int low);
    data   = 8'($urandom_range(0, 255));
    STROBE = 1'b0;
    repeat (low) tick();
    STROBE = 1'b1;
    repeat (STBM + 3) tick();
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (fifo_count == 0) break;
      tick();
    end
    rx_ready = 1'b0;
    tick();
    check("drain_empty", 32'(fifo_count), 32'd0);
  endtask

  // Monitor: ACK falling edge marks the push; pops are scored against the model head.
  logic ack_prev = 1'b1;
  int   ack_run = 0;
  int   snap_size = 0;
  always @(negedge clk) begin
    if (!reset) begin
      ack_prev  = 1'b1;
      ack_run   = 0;
      snap_size = 0;
    end else begin
      if (!ACK && ack_prev) begin
        ack_seen++;
        if (snap_size >= DEPTH) model_ovf = 1'b1;
        else model_q.push_back(pend_byte);
      end
      if (!ACK) ack_run++;
      else if (!ack_prev) begin
        if (ack_len_chk) check("ack_len", 32'(ack_run), 32'(ACKC));
        ack_run = 0;
      end
      snap_size = model_q.size();
      if (rx_valid && rx_ready) begin
        if (model_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
        else begin
          check("pop_data", 32'(rx_data), 32'(model_q.pop_front()));
          pops++;
        end
      end
      ack_prev = ACK;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit saw;
    int p0;
    logic [7:0] b;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b0; data = 8'h00; STROBE = 1'b1; AFD = 1'b1; INIT = 1'b1; SIN = 1'b1;
    online = 1'b1; paper_out = 1'b0; fault = 1'b0; rx_ready = 1'b0;
    repeat (3) tick();
    check("rst_ack", 32'(ACK), 32'd1);
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_pe", 32'(PE), 32'd0);
    check("rst_selt", 32'(SELT), 32'd0);
    check("rst_err", 32'(ERR), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_autofeed", 32'(autofeed), 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(BUSY), 32'd0);

    // 1: one byte with BUSY latency and WRITE/ACK timing
    data = 8'hA5; pend_byte = 8'hA5; STROBE = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == STBM + 2) check("busy_before_accept", 32'(BUSY), 32'd0);
      if (k == STBM + 3) check("busy_after_accept", 32'(BUSY), 32'd1);
    end
    STROBE = 1'b1; exp_acks++;
    repeat (3) tick();
    check("ack_in_write", 32'(ACK), 32'd1);
    check("rx_valid_in_write", 32'(rx_valid), 32'd0);
    tick();
    check("ack_low_after_write", 32'(ACK), 32'd0);
    check("rx_valid_after_write", 32'(rx_valid), 32'd1);
    wait_ack(1'b1, ok);
    check("ack_rise_seen", 32'(ok), 32'd1);
    repeat (2) tick();
    check("t1_rx_data", 32'(rx_data), 32'h0A5);
    check("t1_count", 32'(fifo_count), 32'd1);
    check("t1_busy_idle", 32'(BUSY), 32'd0);
    check("t1_acks", 32'(ack_seen), 32'(exp_acks));
    drain();

    // 2: too-short strobe is filtered; exactly STB_MIN_CYCLES is accepted
    STROBE = 1'b0;
    saw = 1'b0;
    repeat (STBM - 1) tick();
    STROBE = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (BUSY || !ACK) saw = 1'b1;
    end
    check("glitch_no_busy_ack", 32'(saw), 32'd0);
    check("glitch_count", 32'(fifo_count), 32'd0);
    send_byte(8'h3C, STBM);
    check("min_strobe_count", 32'(fifo_count), 32'd1);
    check("min_strobe_acks", 32'(ack_seen), 32'(exp_acks));
    drain();

    // 3: fill to full, overflow on 17th, drain in order
    for (int k = 0; k < 16; k++) send_byte(8'(k), STBM + 2);
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_busy", 32'(BUSY), 32'd1);
    check("full_no_overflow", 32'(overflow), 32'd0);
    send_byte(8'h10, STBM + 2);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd16);
    check("ovf_acks", 32'(ack_seen), 32'(exp_acks));
    p0 = pops;
    drain();
    check("ovf_drained", 32'(pops - p0), 32'd16);

    // 4: push and pop on the same edge keep occupancy at one
    send_byte(8'h40, STBM + 2);
    for (int j = 0; j < 6; j++) begin
      b = 8'h41 + 8'(j);
      data = b; pend_byte = b; STROBE = 1'b0;
      repeat (STBM + 2) tick();
      STROBE = 1'b1; exp_acks++;
      repeat (3) tick();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("stream_count", 32'(fifo_count), 32'd1);
      wait_ack(1'b1, ok);
      check("stream_ack_rise", 32'(ok), 32'd1);
      repeat (2) tick();
      check("stream_count_steady", 32'(fifo_count), 32'd1);
    end
    drain();

    // 5: INIT in the middle of an ACK pulse with 3 bytes buffered
    send_byte(8'h51, STBM + 2);
    send_byte(8'h52, STBM + 2);
    data = 8'h53; pend_byte = 8'h53; STROBE = 1'b0;
    repeat (STBM + 2) tick();
    STROBE = 1'b1; exp_acks++;
    wait_ack(1'b0, ok);
    check("init_ack_fall", 32'(ok), 32'd1);
    repeat (3) tick();
    check("init_pre_count", 32'(fifo_count), 32'd3);
    check("init_pre_overflow", 32'(overflow), 32'd1);
    ack_len_chk = 1'b0;
    INIT = 1'b0;
    repeat (2) tick();
    check("init_ack_still_low", 32'(ACK), 32'd0);
    tick();
    check("init_ack_released", 32'(ACK), 32'd1);
    check("init_flush", 32'(fifo_count), 32'd0);
    check("init_ovf_clear", 32'(overflow), 32'd0);
    check("init_rx_valid", 32'(rx_valid), 32'd0);
    model_q.delete();
    model_ovf = 1'b0;
    repeat (8) tick();
    check("init_busy_hold", 32'(BUSY), 32'd1);
    INIT = 1'b1;
    repeat (3) tick();
    check("init_busy_until_idle", 32'(BUSY), 32'd1);
    tick();
    check("init_busy_release", 32'(BUSY), 32'd0);
    ack_len_chk = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      rdy_num  = (i < 20) ? 1 : 32;
      rand_rdy = 1'b1;
      if ($urandom_range(0, 2) == 0) glitch($urandom_range(1, STBM - 1));
      send_byte(8'($urandom_range(0, 255)), $urandom_range(STBM, STBM + 6));
      rand_rdy = 1'b0;
      rx_ready = 1'b0;
      repeat (2) tick();
      check("rnd_count", 32'(fifo_count), 32'(model_q.size()));
      check("rnd_valid", 32'(rx_valid), 32'(model_q.size() != 0));
      check("rnd_busy", 32'(BUSY), 32'(model_q.size() == DEPTH));
      check("rnd_overflow", 32'(overflow), 32'(model_ovf));
      check("rnd_acks", 32'(ack_seen), 32'(exp_acks));
    end
    drain();

    // 6: status pins from the vector table
    for (int v = 0; v < 6; v++) begin
      online = vecs[v].online; fault = vecs[v].fault; paper_out = vecs[v].paper_out;
      SIN = vecs[v].sin; AFD = vecs[v].afd;
      repeat (4) tick();
      check($sformatf("vec%0d_busy", v), 32'(BUSY), 32'(vecs[v].busy));
      check($sformatf("vec%0d_err", v), 32'(ERR), 32'(vecs[v].err));
      check($sformatf("vec%0d_pe", v), 32'(PE), 32'(vecs[v].pe));
      check($sformatf("vec%0d_selt", v), 32'(SELT), 32'(vecs[v].selt));
      check($sformatf("vec%0d_autofeed", v), 32'(autofeed), 32'(vecs[v].autofeed));
    end

    // one-cycle status latency
    online = 1'b1; fault = 1'b0; paper_out = 1'b0; SIN = 1'b1; AFD = 1'b1;
    repeat (4) tick();
    fault = 1'b1;
    check("err_before_edge", 32'(ERR), 32'd1);
    tick();
    check("err_one_cycle", 32'(ERR), 32'd0);
    check("busy_fault_one_cycle", 32'(BUSY), 32'd1);
    fault = 1'b0; paper_out = 1'b1;
    check("pe_before_edge", 32'(PE), 32'd0);
    tick();
    check("pe_one_cycle", 32'(PE), 32'd1);
    check("final_acks", 32'(ack_seen), 32'(exp_acks));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
